// File: rtl/drop_speed_ctrl.sv
// Gravity-rate control: counts cleared lines into a level, maps the level to a
// gravity period reduction, and debounces the soft-drop button. A game-state FSM gates both outputs.
module drop_speed_ctrl #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9,
    parameter int STEP            = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        lines_valid,
    input  logic [2:0]  lines_cleared,
    input  logic        btn_down,
    output logic        running,
    output logic [3:0]  level,
    output logic [9:0]  lines_total,
    output logic [24:0] scoremod,
    output logic        speed_up
);

    typedef enum logic [1:0] {G_STOPPED, G_RUNNING, G_OVER} game_state_e;
    typedef enum logic [1:0] {D_RELEASED, D_ARMING, D_PRESSED, D_DISARMING} deb_state_e;

    localparam int LIL_W = $clog2(LINES_PER_LEVEL);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [LIL_W:0]   LPL       = (LIL_W+1)'(LINES_PER_LEVEL);
    localparam logic [LIL_W-1:0] LIL_MAX   = LIL_W'(LINES_PER_LEVEL - 1);
    localparam logic [3:0]       MAX_LVL   = 4'(MAX_LEVEL);
    localparam logic [24:0]      STEP_V    = 25'(STEP);
    localparam logic [9:0]       TOTAL_MAX = 10'd999;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    game_state_e      game_q, game_d;
    logic             running_q, running_d;
    logic [3:0]       level_q, level_d;
    logic [9:0]       lines_total_q, lines_total_d;
    logic [LIL_W-1:0] lines_in_level_q, lines_in_level_d;
    logic [24:0]      scoremod_q, scoremod_d;
    logic             sync_meta_q, sync_meta_d;
    logic             sync_q, sync_d;
    deb_state_e       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             speed_up_q, speed_up_d;

    logic [2:0]       n;
    logic [LIL_W:0]   sum;
    logic [10:0]      total_sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        game_d = game_q;
        if (game_start)
            game_d = G_RUNNING;
        else if (game_q == G_RUNNING && game_over)
            game_d = G_OVER;
        running_d = (game_d == G_RUNNING);
    end

    always_comb begin
        n                = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        sum              = (LIL_W+1)'(lines_in_level_q) + (LIL_W+1)'(n);
        total_sum        = 11'(lines_total_q) + 11'(n);
        level_d          = level_q;
        lines_total_d    = lines_total_q;
        lines_in_level_d = lines_in_level_q;
        scoremod_d       = 25'(level_q) * STEP_V;
        if (game_start) begin
            // A start in the same cycle as a line event wins; those lines are dropped.
            level_d          = '0;
            lines_total_d    = '0;
            lines_in_level_d = '0;
            scoremod_d       = '0;
        end else if (game_q == G_RUNNING && lines_valid) begin
            lines_total_d = (total_sum > 11'(TOTAL_MAX)) ? TOTAL_MAX : total_sum[9:0];
            if (sum >= LPL && level_q < MAX_LVL) begin
                level_d          = level_q + 4'd1;
                lines_in_level_d = LIL_W'(sum - LPL);
            end else if (sum > (LIL_W+1)'(LIL_MAX)) begin
                lines_in_level_d = LIL_MAX;
            end else begin
                lines_in_level_d = LIL_W'(sum);
            end
        end
    end

    // NOTE: btn_down is asynchronous, so it passes two flops before any logic looks at it.
    always_comb begin
        sync_meta_d = btn_down;
        sync_d      = sync_meta_q;
        deb_d       = deb_q;
        cnt_d       = cnt_q;
        unique case (deb_q)
            D_RELEASED: if (sync_q) begin
                deb_d = D_ARMING;
                cnt_d = CNT_W'(1);
            end
            D_ARMING: if (!sync_q) begin
                deb_d = D_RELEASED;
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_d = D_PRESSED;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            D_PRESSED: if (!sync_q) begin
                deb_d = D_DISARMING;
                cnt_d = CNT_W'(1);
            end
            D_DISARMING: if (sync_q) begin
                deb_d = D_PRESSED;
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_d = D_RELEASED;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                deb_d = D_RELEASED;
                cnt_d = '0;
            end
        endcase
        // Gate on the next game state so soft drop follows running edge-for-edge.
        speed_up_d = (deb_q == D_PRESSED || deb_q == D_DISARMING) && (game_d == G_RUNNING);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_q           <= G_STOPPED;
            running_q        <= 1'b0;
            level_q          <= '0;
            lines_total_q    <= '0;
            lines_in_level_q <= '0;
            scoremod_q       <= '0;
            sync_meta_q      <= 1'b0;
            sync_q           <= 1'b0;
            deb_q            <= D_RELEASED;
            cnt_q            <= '0;
            speed_up_q       <= 1'b0;
        end else begin
            game_q           <= game_d;
            running_q        <= running_d;
            level_q          <= level_d;
            lines_total_q    <= lines_total_d;
            lines_in_level_q <= lines_in_level_d;
            scoremod_q       <= scoremod_d;
            sync_meta_q      <= sync_meta_d;
            sync_q           <= sync_d;
            deb_q            <= deb_d;
            cnt_q            <= cnt_d;
            speed_up_q       <= speed_up_d;
        end
    end

    assign running     = running_q;
    assign level       = level_q;
    assign lines_total = lines_total_q;
    assign scoremod    = scoremod_q;
    assign speed_up    = speed_up_q;

endmodule
